// File: rtl/uart_arb_pkg.sv
// Shared types, constants and helpers for the UART TX packet arbiter.
package uart_arb_pkg;

    localparam int unsigned ST_W            = 1;
    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned MAX_PKT_DEF     = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 100000;

    typedef enum logic [ST_W-1:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time width sizing.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_any
);

    localparam int unsigned DW = 2 * N;

    logic [N-1:0]  w_hi;
    logic [DW-1:0] w_dreq;
    logic [DW-1:0] w_low;

    always_comb begin
        w_hi = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_hi[i] = (i > int'(i_rr_ptr));
        end
    end

    // Lower half holds requests above the pointer; upper half is the wrapped full set.
    assign w_dreq = {i_req, i_req & w_hi};
    assign w_low  = w_dreq & (~w_dreq + DW'(1));
    assign o_pick = w_low[N-1:0] | w_low[DW-1:N];
    assign o_any  = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing the UART TX FIFO push port among NUM_REQ sources.
// Define UART_TX_ARB_TIMEOUT_EN to release a stalled owner after TIMEOUT_CYC idle cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MAX_PKT = MAX_PKT_DEF
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      trunc
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    localparam int unsigned PW    = clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2(MAX_PKT + 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TO_W  = clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]   r_to_cnt;
`endif

    state_t            r_state;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     r_gidx;
    logic [CNT_W-1:0]  r_byte_cnt;

    logic [NUM_REQ-1:0] w_pick;
    logic               w_any;
    logic [PW-1:0]      w_pick_idx;
    logic               w_gvalid;
    logic               w_glast;
    logic [DATA_W-1:0]  w_gdata;
    logic               w_push;
    logic               w_at_max;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick),
        .o_any    (w_any)
    );

    // Encode the pick and mux out the current owner's handshake signals.
    always_comb begin
        w_pick_idx = '0;
        w_gvalid   = 1'b0;
        w_glast    = 1'b0;
        w_gdata    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_pick[i]) w_pick_idx = PW'(i);
            if (r_gidx == PW'(i)) begin
                w_gvalid = req_valid[i];
                w_glast  = req_last[i];
                w_gdata  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_push     = (r_state == XFER) & w_gvalid & ~fifo_full;
    assign w_at_max   = (r_byte_cnt == CNT_W'(MAX_PKT - 1));
    assign fifo_push  = w_push;
    assign req_ready  = grant & {NUM_REQ{~fifo_full}};
    assign fifo_wdata = (r_state == XFER) ? w_gdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= PW'(NUM_REQ - 1);
            r_gidx     <= '0;
            r_byte_cnt <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            trunc      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_to_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            trunc <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (r_state == IDLE) begin
                if (w_any) begin
                    grant   <= w_pick;
                    r_gidx  <= w_pick_idx;
                    r_state <= XFER;
                    busy    <= 1'b1;
                end
            end else begin
                // Packet ends on last, or is cut at MAX_PKT bytes.
                if (w_push && (w_glast || w_at_max)) begin
                    r_rr_ptr   <= r_gidx;
                    grant      <= '0;
                    r_byte_cnt <= '0;
                    r_state    <= IDLE;
                    busy       <= 1'b0;
                    trunc      <= ~w_glast;
                end else if (w_push) begin
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // Only a missing byte from the owner counts; FIFO stalls do not.
                if (w_push) begin
                    r_to_cnt <= '0;
                end else if (!w_gvalid) begin
                    if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_to_cnt   <= '0;
                        r_rr_ptr   <= r_gidx;
                        grant      <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= IDLE;
                        busy       <= 1'b0;
                        timeout    <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, MAX_PKT=4).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_push;
    logic [7:0]  fifo_wdata;
    logic [3:0]  grant;
    logic        busy;
    logic        trunc;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .MAX_PKT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy),
        .trunc      (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] q [4][$];
    logic [3:0] en;
    logic [7:0] pushed[$];
    logic [3:0] glog[$];
    logic [3:0] prev_grant;
    logic [3:0] s_grant, s_ready;
    logic       s_push, s_busy, s_trunc;
    logic [7:0] s_wdata;
    int         trunc_cnt;
    int         trunc_at;
    logic [7:0] exp_q[$];
    logic [3:0] exp_g[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0 && en[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = q[i][0][7:0];
                req_last[i]        = q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Sample on the falling edge, then let requesters retire accepted bytes after the rising edge.
    task automatic tick();
        logic [3:0] rdy;
        @(negedge clk);
        s_grant = grant;
        s_push  = fifo_push;
        s_wdata = fifo_wdata;
        s_ready = req_ready;
        s_busy  = busy;
        s_trunc = trunc;
        rdy     = req_ready;
        if (s_push) pushed.push_back(s_wdata);
        if (s_trunc) begin
            trunc_cnt++;
            trunc_at = pushed.size();
        end
        if (s_grant != 4'b0000 && s_grant != prev_grant) glog.push_back(s_grant);
        prev_grant = s_grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i] && req_valid[i]) void'(q[i].pop_front());
        end
        drive();
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (pushed.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, 32'(pushed.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < pushed.size()) chk($sformatf("%s[%0d]", tag, i), 32'(pushed[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        fifo_full  = 1'b0;
        en         = 4'b1111;
        prev_grant = 4'b0000;
        trunc_cnt  = 0;
        trunc_at   = 0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 3; b++) q[i].push_back({(b == 2), 4'(4'hA + i), 4'(b)});
        end
        drive();

        // Reset held with all requesters valid.
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_push", 32'(fifo_push), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_trunc", 32'(trunc), 32'h0);
        chk("rst_wdata", 32'(fifo_wdata), 32'h0);
        rst = 1'b1;

        tick();
        chk("first_grant", 32'(s_grant), 32'h1);
        chk("first_busy", 32'(s_busy), 32'h1);
        chk("first_ready", 32'(s_ready), 32'h1);
        chk("first_byte", 32'(s_wdata), 32'hA0);

        // Round robin across all four, then wrap back to req0.
        run_until(12, 100);
        tick();
        chk("gap_busy", 32'(s_busy), 32'h0);
        chk("gap_grant", 32'(s_grant), 32'h0);
        q[0].push_back({1'b1, 8'h30});
        q[3].push_back({1'b1, 8'h31});
        drive();
        run_until(14, 30);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1, 8'hC2,
                  8'hD0, 8'hD1, 8'hD2, 8'h30, 8'h31};
        chk_stream("rr", exp_q);
        exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h8};
        chk("glog_len", 32'(glog.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size(); i++) begin
            if (i < glog.size()) chk($sformatf("glog[%0d]", i), 32'(glog[i]), 32'(exp_g[i]));
        end
        repeat (2) tick();

        // Back-pressure after 0x42.
        pushed.delete();
        q[2].push_back({1'b0, 8'h41});
        q[2].push_back({1'b0, 8'h42});
        q[2].push_back({1'b1, 8'h43});
        drive();
        run_until(2, 20);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_push%0d", k), 32'(s_push), 32'h0);
            chk($sformatf("bp_ready%0d", k), 32'(s_ready), 32'h0);
            chk($sformatf("bp_grant%0d", k), 32'(s_grant), 32'h4);
        end
        fifo_full = 1'b0;
        tick();
        chk("bp_resume_push", 32'(s_push), 32'h1);
        chk("bp_resume_data", 32'(s_wdata), 32'h43);
        repeat (2) tick();
        exp_q = '{8'h41, 8'h42, 8'h43};
        chk_stream("bp", exp_q);

        // Owner drops valid mid-packet while req2 waits.
        pushed.delete();
        q[1].push_back({1'b0, 8'h51});
        q[1].push_back({1'b0, 8'h52});
        q[1].push_back({1'b1, 8'h53});
        q[2].push_back({1'b1, 8'h61});
        drive();
        run_until(1, 20);
        en[1] = 1'b0;
        drive();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("vg_grant%0d", k), 32'(s_grant), 32'h2);
            chk($sformatf("vg_push%0d", k), 32'(s_push), 32'h0);
        end
        en[1] = 1'b1;
        drive();
        run_until(4, 30);
        exp_q = '{8'h51, 8'h52, 8'h53, 8'h61};
        chk_stream("vg", exp_q);
        repeat (2) tick();

        // Six-byte packet cut at four; pending req1 slips in between.
        pushed.delete();
        trunc_cnt = 0;
        trunc_at  = 0;
        for (int b = 1; b <= 6; b++) q[0].push_back({(b == 6), 8'(8'h70 + b)});
        q[1].push_back({1'b1, 8'h81});
        drive();
        run_until(7, 60);
        repeat (2) tick();
        exp_q = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h81, 8'h75, 8'h76};
        chk_stream("mp", exp_q);
        chk("mp_trunc_cnt", 32'(trunc_cnt), 32'd1);
        chk("mp_trunc_at", 32'(trunc_at), 32'd4);
        chk("end_busy", 32'(s_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin packet arbiter that shares the single UART TX FIFO write port among NUM_REQ message sources (DHT11 report, ultrasonic report, clock/stopwatch report, RX echo).
- Grants one requester for a whole packet (byte stream terminated by last) so packets from different sources never interleave on tx.
- Sits between the report generators and the TX FIFO push side inside project_UART_FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- MAX_PKT, 32, maximum bytes per packet before a forced release
- TIMEOUT_CYC, 100000, idle-cycle limit while granted (optional feature only; 1 ms at 100 MHz)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks final byte of packet
- req_ready  out  NUM_REQ  byte accepted this cycle
- fifo_full  in  1  TX FIFO full
- fifo_push  out  1  TX FIFO write strobe
- fifo_wdata  out  DATA_W  TX FIFO write data
- grant  out  NUM_REQ  one-hot current owner, registered
- busy  out  1  high while in XFER
- trunc  out  1  one-cycle pulse on MAX_PKT forced release

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, rr_ptr=NUM_REQ-1, byte_cnt=0, busy=0, trunc=0. Combinational outputs fifo_push=0, req_ready=0, fifo_wdata=0 while grant=0. Reset mid-packet aborts the packet. Any bytes already pushed stay in the FIFO.
- FSM IDLE:
  - Scan req_valid from (rr_ptr+1) mod NUM_REQ, wrapping.
  - The first set bit wins. On the next edge, grant is set to that one-hot value and state goes to XFER.
  - Arbitration latency is 1 cycle; no byte moves in IDLE.
- FSM XFER, g = granted index:
  - req_ready[g] = !fifo_full. All other req_ready = 0.
  - fifo_push = req_valid[g] & !fifo_full.
  - fifo_wdata = req_data[g] when g is granted, else 0.
  - Each push increments byte_cnt (width clog2(MAX_PKT+1)).
- Handshake: the requester holds valid, data and last stable until req_ready is high. A transfer occurs only when valid and ready are both high in the same cycle.
- req_valid[g] low mid-packet: stay in XFER and keep grant (the packet is incomplete).
- fifo_full high: no push and ready=0. Grant is held, and data is presented again on the next cycle.
- Packet end (push with req_last[g]=1): on the next edge, rr_ptr=g, grant=0, byte_cnt=0, state=IDLE.
  - The fastest turnaround is 1 idle cycle between packets.
  - The same requester is lowest priority in the next scan.
- Forced release: a push while byte_cnt==MAX_PKT-1 and last=0 ends the packet as if last were set, and trunc pulses for 1 cycle on that edge. The requester's remaining bytes then compete as a new packet.
- Simultaneous requests are resolved strictly round-robin. An owner cannot be pre-empted except by MAX_PKT or the optional timeout.
- A requester asserting valid while not granted has no effect; no byte is lost.
- busy = (state==XFER).

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in XFER while req_valid[g]=0. It clears on any push.
  - On reaching TIMEOUT_CYC, grant is released (state IDLE, rr_ptr=g) and extra output port timeout pulses for 1 cycle.
  - fifo_full stalls do not count.
- Undefined: no counter and no timeout port. A stalled owner holds the grant indefinitely.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, XFER), ST_W, function clog2, and default constants (NUM_REQ_DEF, MAX_PKT_DEF, TIMEOUT_CYC_DEF).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick, any.
  - Implemented with a doubled-vector mask; reusable for future RX-side routing.

Test Plan:
- Reset: hold rst=0 with req_valid=4'b1111 -> grant=0, fifo_push=0, req_ready=0. Release rst -> grant=4'b0001 one cycle later.
- Round-robin: all four requesters send 3-byte packets (0xA0..A2, 0xB0..B2, 0xC0..C2, 0xD0..D2) -> FIFO receives A0 A1 A2 B0 B1 B2 C0 C1 C2 D0 D1 D2 with no interleaving, then grant order repeats starting at req0.
- Back-pressure: fifo_full=1 for 5 cycles mid-packet after byte 0x42 -> no push, req_ready=0, grant unchanged. Byte 0x43 is pushed the first cycle fifo_full=0.
- Valid gap: req1 drops valid for 10 cycles mid-packet while req2 is valid -> grant stays 4'b0010, req2 is served only after req1's last byte.
- MAX_PKT: MAX_PKT=4, req0 sends 6 bytes with last on byte 6 -> trunc pulses after byte 4; req1 (pending) is granted next; req0's bytes 5-6 follow as a separate packet.
- Timeout (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): req3 granted then stalls with valid=0 -> timeout pulses at cycle 16 of the stall, grant=0, and the next requester is granted the following cycle.
